// File: rtl/agu_queue.sv
// agu_queue: address-generation unit with an elastic output queue, between issue and the LSU.
//   - Effective address ea = rs1 + imm (mod 2^32), store byte mask and lane-aligned store data.
//   - Drives the DTLB/PMP probe (d_addr, d_write) combinationally and takes the same-cycle d_kill.
//   - Good ops (and every CMO) go into a QDEPTH-entry FIFO whose head drives the lsu_* outputs.
//   - Misaligned or killed non-CMO ops raise a one-cycle registered exception pulse instead.
// Ports:
//   cpu_clock_i, cpu_reset_ni (synchronous, active-low), flush_i
//   agu_vld_i / agu_busy_o and agu_* operands   : issue side
//   lsu_vld_o / lsu_busy_i and lsu_* head fields : LSU side
//   excp_valid, excp_pc, excp_code_o, excp_rob   : exception report
//   d_addr, d_write, d_kill                      : translation / protection probe
// Optional build macro AGU_PERF_COUNTERS_EN adds perf_misalign_o, perf_fault_o, perf_stall_o.
module agu_queue #(
  parameter int ROB_W      = 6,
  parameter int DEST_W     = 6,
  parameter int QDEPTH     = 2,
  parameter int PAGE_SHIFT = 7
) (
  input  logic                  cpu_clock_i,
  input  logic                  cpu_reset_ni,
  input  logic                  flush_i,
  output logic                  agu_busy_o,
  input  logic                  agu_vld_i,
  input  logic [ROB_W-1:0]      agu_rob_i,
  input  logic                  agu_cmo_i,
  input  logic [3:0]            agu_op_i,
  input  logic [31:0]           agu_rs1_i,
  input  logic [31:0]           agu_rs2_i,
  input  logic [31:0]           agu_imm_i,
  input  logic [DEST_W-1:0]     agu_dest_i,
  input  logic                  lsu_busy_i,
  output logic                  lsu_vld_o,
  output logic [ROB_W-1:0]      lsu_rob_o,
  output logic                  lsu_cmo_o,
  output logic [3:0]            lsu_op_o,
  output logic [31:0]           lsu_addr_o,
  output logic [31:0]           lsu_data_o,
  output logic [DEST_W-1:0]     lsu_dest_o,
  output logic [31:0]           lsu_sq_data_o,
  output logic [3:0]            lsu_sq_bm_o,
  output logic                  excp_valid,
  output logic [31:0]           excp_pc,
  output logic [3:0]            excp_code_o,
  output logic [ROB_W-1:0]      excp_rob,
  output logic [31-PAGE_SHIFT:0] d_addr,
  output logic                  d_write,
  input  logic                  d_kill
`ifdef AGU_PERF_COUNTERS_EN
  ,
  output logic [31:0]           perf_misalign_o,
  output logic [31:0]           perf_fault_o,
  output logic [31:0]           perf_stall_o
`endif
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic              cmo;
    logic [3:0]        op;
    logic [31:0]       addr;
    logic [31:0]       data;
    logic [DEST_W-1:0] dest;
    logic [31:0]       sq_data;
    logic [3:0]        bm;
  } entry_t;

  entry_t            mem_q [QDEPTH];
  entry_t            mem_d [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              excp_valid_q, excp_valid_d;
  logic [31:0]       excp_pc_q, excp_pc_d;
  logic [3:0]        excp_code_q, excp_code_d;
  logic [ROB_W-1:0]  excp_rob_q, excp_rob_d;

  logic [31:0]       ea;
  logic [3:0]        bm;
  logic [31:0]       sq_data;
  logic              misaligned;
  logic              accept, push, pop, raise;
  entry_t            new_entry;

  assign ea      = agu_rs1_i + agu_imm_i;
  assign d_addr  = ea[31:PAGE_SHIFT];
  assign d_write = agu_op_i[3];

  // Byte mask, lane-aligned store data and misalignment from {ea[1:0], size}.
  always_comb begin
    bm         = 4'b0110;
    sq_data    = 32'h0000_0000;
    misaligned = 1'b1;
    case ({ea[1:0], agu_op_i[1:0]})
      4'b00_00: begin bm = 4'b0001; sq_data = {24'h00_0000, agu_rs2_i[7:0]};          misaligned = 1'b0; end
      4'b01_00: begin bm = 4'b0010; sq_data = {16'h0000, agu_rs2_i[7:0], 8'h00};      misaligned = 1'b0; end
      4'b10_00: begin bm = 4'b0100; sq_data = {8'h00, agu_rs2_i[7:0], 16'h0000};      misaligned = 1'b0; end
      4'b11_00: begin bm = 4'b1000; sq_data = {agu_rs2_i[7:0], 24'h00_0000};          misaligned = 1'b0; end
      4'b00_01: begin bm = 4'b0011; sq_data = agu_rs2_i;                              misaligned = 1'b0; end
      4'b10_01: begin bm = 4'b1100; sq_data = {agu_rs2_i[15:0], 16'h0000};            misaligned = 1'b0; end
      4'b00_10: begin bm = 4'b1111; sq_data = agu_rs2_i;                              misaligned = 1'b0; end
      default:  begin bm = 4'b0110; sq_data = 32'h0000_0000;                          misaligned = 1'b1; end
    endcase
  end

  assign agu_busy_o = (count_q == CNT_W'(QDEPTH));
  assign lsu_vld_o  = (count_q != {CNT_W{1'b0}});
  // Issue is ignored during a flush cycle; CMOs bypass both misalignment and d_kill.
  assign accept     = agu_vld_i & ~agu_busy_o & ~flush_i;
  assign push       = accept & (agu_cmo_i | ~(misaligned | d_kill));
  assign raise      = accept & ~agu_cmo_i & (misaligned | d_kill);
  assign pop        = lsu_vld_o & ~lsu_busy_i;

  assign new_entry = '{rob: agu_rob_i, cmo: agu_cmo_i, op: agu_op_i, addr: ea, data: agu_rs2_i,
                       dest: agu_dest_i, sq_data: sq_data, bm: bm};

  // Queue pointers, occupancy, payload writes and exception capture.
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    excp_valid_d = raise;
    excp_pc_d    = excp_pc_q;
    excp_code_d  = excp_code_q;
    excp_rob_d   = excp_rob_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    if (raise) begin
      excp_pc_d   = ea;
      excp_rob_d  = agu_rob_i;
      excp_code_d = d_kill ? (agu_op_i[3] ? 4'd7 : 4'd5) : (agu_op_i[3] ? 4'd6 : 4'd4);
    end else begin
      excp_pc_d   = excp_pc_q;
      excp_rob_d  = excp_rob_q;
      excp_code_d = excp_code_q;
    end
  end

  // Control and exception registers with synchronous active-low reset.
  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_reset_ni) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      excp_valid_q <= 1'b0;
      excp_pc_q    <= 32'h0000_0000;
      excp_code_q  <= 4'd0;
      excp_rob_q   <= {ROB_W{1'b0}};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      excp_valid_q <= excp_valid_d;
      excp_pc_q    <= excp_pc_d;
      excp_code_q  <= excp_code_d;
      excp_rob_q   <= excp_rob_d;
    end
  end

  // Queue payload storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge cpu_clock_i) begin
    mem_q <= mem_d;
  end

  assign lsu_rob_o     = mem_q[rd_ptr_q].rob;
  assign lsu_cmo_o     = mem_q[rd_ptr_q].cmo;
  assign lsu_op_o      = mem_q[rd_ptr_q].op;
  assign lsu_addr_o    = mem_q[rd_ptr_q].addr;
  assign lsu_data_o    = mem_q[rd_ptr_q].data;
  assign lsu_dest_o    = mem_q[rd_ptr_q].dest;
  assign lsu_sq_data_o = mem_q[rd_ptr_q].sq_data;
  assign lsu_sq_bm_o   = mem_q[rd_ptr_q].bm;
  assign excp_valid    = excp_valid_q;
  assign excp_pc       = excp_pc_q;
  assign excp_code_o   = excp_code_q;
  assign excp_rob      = excp_rob_q;

`ifdef AGU_PERF_COUNTERS_EN
  logic [31:0] perf_misalign_q, perf_misalign_d;
  logic [31:0] perf_fault_q, perf_fault_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Event counters; they survive flush and wrap naturally at 2^32.
  always_comb begin
    perf_misalign_d = perf_misalign_q + 32'(raise & misaligned & ~d_kill);
    perf_fault_d    = perf_fault_q + 32'(raise & d_kill);
    perf_stall_d    = perf_stall_q + 32'(agu_vld_i & agu_busy_o);
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_reset_ni) begin
      perf_misalign_q <= 32'h0000_0000;
      perf_fault_q    <= 32'h0000_0000;
      perf_stall_q    <= 32'h0000_0000;
    end else begin
      perf_misalign_q <= perf_misalign_d;
      perf_fault_q    <= perf_fault_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign perf_misalign_o = perf_misalign_q;
  assign perf_fault_o    = perf_fault_q;
  assign perf_stall_o    = perf_stall_q;
`endif

endmodule
